// File: rtl/riscv_pkg.sv
// Decode constants, FSM encoding and byte-lane helpers shared by the RV64 MEM stage.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ABORT = 2'd2
   } mem_state_e;

   // Everything about the in-flight access needed once the response returns.
   typedef struct packed {
      logic       is_store;
      logic [2:0] funct3;
      logic [2:0] addr_lo;
   } mem_op_t;

   function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] lo);
      logic r_mis;
      case (size)
         SZ_B:    r_mis = 1'b0;
         SZ_H:    r_mis = lo[0];
         SZ_W:    r_mis = |lo[1:0];
         default: r_mis = |lo;
      endcase
      return r_mis;
   endfunction

   function automatic logic [7:0] lane_strobe(input mem_size_e size, input logic [2:0] lo);
      logic [7:0] r_base;
      case (size)
         SZ_B:    r_base = 8'h01;
         SZ_H:    r_base = 8'h03;
         SZ_W:    r_base = 8'h0F;
         default: r_base = 8'hFF;
      endcase
      return r_base << lo;
   endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Selects the addressed lane of a 64-bit read doubleword and sign/zero-extends it.
module load_align
   import riscv_pkg::*;
(
   input  logic [63:0] i_rdata,
   input  logic [2:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [63:0] o_result
);

   logic [63:0] w_shift;
   logic        w_sext;

   assign w_shift = i_rdata >> {i_addr_lo, 3'b000};
   assign w_sext  = ~i_funct3[2];

   always_comb begin
      // NOTE: default assignment first so every path drives o_result and no latch is inferred.
      o_result = '0;
      case (mem_size_e'(i_funct3[1:0]))
         SZ_B:    o_result = {{56{w_sext & w_shift[7]}},  w_shift[7:0]};
         SZ_H:    o_result = {{48{w_sext & w_shift[15]}}, w_shift[15:0]};
         SZ_W:    o_result = {{32{w_sext & w_shift[31]}}, w_shift[31:0]};
         default: o_result = w_shift;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// RV64 MEM stage: ready/valid data-memory access with lane alignment and fault detection,
// plus the MEM/WB pipeline latch feeding writeback.
module memory_stage
   import riscv_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 256
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            MEM_V,
   input  logic            MEM_FLUSH,
   input  logic [31:0]     MEM_IR,
   input  logic [XLEN-1:0] MEM_NPC,
   input  logic [XLEN-1:0] MEM_ALU_RESULT,
   input  logic [XLEN-1:0] MEM_STORE_DATA,
   input  logic [XLEN-1:0] MEM_CSRFD,
   input  logic [XLEN-1:0] MEM_RFD,
   input  logic [4:0]      MEM_DRID,
   input  logic            MEM_ECALL,
   input  logic            MEM_BR_TAKEN,
   input  logic [63:0]     DMEM_RDATA,
   input  logic            DMEM_READY,
   input  logic            DMEM_ERR,
   output logic            DMEM_REQ,
   output logic            DMEM_WE,
   output logic [XLEN-1:0] DMEM_ADDR,
   output logic [63:0]     DMEM_WDATA,
   output logic [7:0]      DMEM_WSTRB,
   output logic            MEM_STALL,
   output logic            MEM_PC_MUX,
   output logic            WB_V,
   output logic [31:0]     WB_IR,
   output logic [XLEN-1:0] WB_NPC,
   output logic [XLEN-1:0] WB_ALU_RESULT,
   output logic [XLEN-1:0] WB_MEM_RESULT,
   output logic [XLEN-1:0] WB_CSRFD,
   output logic [XLEN-1:0] WB_RFD,
   output logic [4:0]      WB_DRID,
   output logic            WB_ECALL,
   output logic            MEM_LAM,
   output logic            MEM_LAF,
   output logic            MEM_SAM,
   output logic            MEM_SAF
);

   localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT);

   mem_state_e    r_state;
   logic [CW-1:0] r_cnt;
   mem_op_t       r_op;

   logic [6:0]  w_opcode;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_is_mem;
   logic        w_misal;
   logic        w_start;
   logic        w_timeout;
   logic        w_wb_load;
   logic        w_fault;
   mem_size_e   w_size;
   logic [2:0]  w_lo;
   logic [63:0] w_load_data;

   assign w_opcode   = MEM_IR[6:0];
   assign w_size     = mem_size_e'(MEM_IR[13:12]);
   assign w_lo       = MEM_ALU_RESULT[2:0];
   assign w_is_load  = (w_opcode == OPC_LOAD);
   assign w_is_store = (w_opcode == OPC_STORE);
   assign w_is_mem   = MEM_V & (w_is_load | w_is_store);
   assign w_misal    = w_is_mem & is_misaligned(w_size, w_lo);
   assign w_start    = w_is_mem & ~w_misal & ~MEM_FLUSH;
   assign w_timeout  = (TIMEOUT != 0) && (r_cnt >= CNT_LIM);
   assign w_wb_load  = ~MEM_FLUSH & ~MEM_STALL;
   // A completion without READY can only be the timeout path.
   assign w_fault    = DMEM_READY ? DMEM_ERR : 1'b1;

   load_align u_load_align (
      .i_rdata   (DMEM_RDATA),
      .i_addr_lo (r_op.addr_lo),
      .i_funct3  (r_op.funct3),
      .o_result  (w_load_data)
   );

   always_comb begin
      MEM_STALL = 1'b0;
      case (r_state)
         ST_IDLE, ST_ABORT: MEM_STALL = w_start;
         ST_REQ:            MEM_STALL = ~MEM_FLUSH & ~DMEM_READY & ~w_timeout;
         default:           MEM_STALL = 1'b0;
      endcase
   end

   // Bus FSM. ABORT keeps the request asserted until the slave answers so the
   // ready/valid handshake is never broken; that late response is discarded.
   always_ff @(posedge CLK) begin
      // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!RESET) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_op       <= '0;
         DMEM_REQ   <= 1'b0;
         DMEM_WE    <= 1'b0;
         DMEM_ADDR  <= '0;
         DMEM_WDATA <= '0;
         DMEM_WSTRB <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state    <= ST_REQ;
                  r_op       <= '{is_store: w_is_store, funct3: MEM_IR[14:12], addr_lo: w_lo};
                  DMEM_REQ   <= 1'b1;
                  DMEM_WE    <= w_is_store;
                  DMEM_ADDR  <= {MEM_ALU_RESULT[XLEN-1:3], 3'b000};
                  DMEM_WDATA <= w_is_store ? (64'(MEM_STORE_DATA) << {w_lo, 3'b000}) : 64'd0;
                  DMEM_WSTRB <= w_is_store ? lane_strobe(w_size, w_lo) : 8'h00;
               end
            end
            ST_REQ: begin
               if (DMEM_READY) begin
                  DMEM_REQ <= 1'b0;
                  r_state  <= ST_IDLE;
               end else if (MEM_FLUSH || w_timeout) begin
                  r_state  <= ST_ABORT;
               end
               if (DMEM_READY || MEM_FLUSH || w_timeout) begin
                  r_cnt <= '0;
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_ABORT: begin
               if (DMEM_READY) begin
                  DMEM_REQ <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // MEM/WB latch: a flush or a stall inserts a bubble with no exception flags.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         WB_V          <= 1'b0;
         WB_IR         <= '0;
         WB_NPC        <= '0;
         WB_ALU_RESULT <= '0;
         WB_MEM_RESULT <= '0;
         WB_CSRFD      <= '0;
         WB_RFD        <= '0;
         WB_DRID       <= '0;
         WB_ECALL      <= 1'b0;
         MEM_PC_MUX    <= 1'b0;
         MEM_LAM       <= 1'b0;
         MEM_LAF       <= 1'b0;
         MEM_SAM       <= 1'b0;
         MEM_SAF       <= 1'b0;
      end else if (!w_wb_load) begin
         WB_V       <= 1'b0;
         MEM_PC_MUX <= 1'b0;
         MEM_LAM    <= 1'b0;
         MEM_LAF    <= 1'b0;
         MEM_SAM    <= 1'b0;
         MEM_SAF    <= 1'b0;
      end else begin
         WB_V          <= MEM_V;
         WB_IR         <= MEM_IR;
         WB_NPC        <= MEM_NPC;
         WB_ALU_RESULT <= MEM_ALU_RESULT;
         WB_CSRFD      <= MEM_CSRFD;
         WB_RFD        <= MEM_RFD;
         WB_DRID       <= MEM_DRID;
         WB_ECALL      <= MEM_ECALL;
         MEM_PC_MUX    <= MEM_V & MEM_BR_TAKEN;
         MEM_LAM       <= w_misal & w_is_load;
         MEM_SAM       <= w_misal & w_is_store;
         if (r_state == ST_REQ) begin
            MEM_LAF       <= MEM_V & ~r_op.is_store & w_fault;
            MEM_SAF       <= MEM_V &  r_op.is_store & w_fault;
            WB_MEM_RESULT <= (r_op.is_store || !DMEM_READY) ? '0 : XLEN'(w_load_data);
         end else begin
            MEM_LAF       <= 1'b0;
            MEM_SAF       <= 1'b0;
            WB_MEM_RESULT <= '0;
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: stimulus pushes expected writeback records into a
// scoreboard that a negedge monitor pops whenever WB_V is presented.
module tb_memory_stage;
   import riscv_pkg::*;

   localparam int XLEN = 64;
   localparam int TMO  = 16;

   logic            CLK = 1'b0;
   logic            RESET;
   logic            MEM_V, MEM_FLUSH, MEM_ECALL, MEM_BR_TAKEN;
   logic [31:0]     MEM_IR;
   logic [XLEN-1:0] MEM_NPC, MEM_ALU_RESULT, MEM_STORE_DATA, MEM_CSRFD, MEM_RFD;
   logic [4:0]      MEM_DRID;
   logic [63:0]     DMEM_RDATA;
   logic            DMEM_READY, DMEM_ERR;
   logic            DMEM_REQ, DMEM_WE;
   logic [XLEN-1:0] DMEM_ADDR;
   logic [63:0]     DMEM_WDATA;
   logic [7:0]      DMEM_WSTRB;
   logic            MEM_STALL, MEM_PC_MUX, WB_V, WB_ECALL;
   logic [31:0]     WB_IR;
   logic [XLEN-1:0] WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_CSRFD, WB_RFD;
   logic [4:0]      WB_DRID;
   logic            MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;

   always #5 CLK = ~CLK;

   memory_stage #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RESET(RESET), .MEM_V(MEM_V), .MEM_FLUSH(MEM_FLUSH), .MEM_IR(MEM_IR),
      .MEM_NPC(MEM_NPC), .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_STORE_DATA(MEM_STORE_DATA),
      .MEM_CSRFD(MEM_CSRFD), .MEM_RFD(MEM_RFD), .MEM_DRID(MEM_DRID), .MEM_ECALL(MEM_ECALL),
      .MEM_BR_TAKEN(MEM_BR_TAKEN), .DMEM_RDATA(DMEM_RDATA), .DMEM_READY(DMEM_READY),
      .DMEM_ERR(DMEM_ERR), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
      .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB), .MEM_STALL(MEM_STALL),
      .MEM_PC_MUX(MEM_PC_MUX), .WB_V(WB_V), .WB_IR(WB_IR), .WB_NPC(WB_NPC),
      .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT), .WB_CSRFD(WB_CSRFD),
      .WB_RFD(WB_RFD), .WB_DRID(WB_DRID), .WB_ECALL(WB_ECALL), .MEM_LAM(MEM_LAM),
      .MEM_LAF(MEM_LAF), .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF)
   );

   typedef struct {
      logic [31:0] ir;
      logic [63:0] alu;
      logic [63:0] res;
      logic        pcmux;
      logic [3:0]  flags;   // {LAM, LAF, SAM, SAF}
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   logic        cap_req, cap_we;
   logic [63:0] cap_addr, cap_wdata;
   logic [7:0]  cap_wstrb;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc, input logic [4:0] rd);
      return {17'd0, f3, rd, opc};
   endfunction

   task automatic push(input logic [31:0] ir, input logic [63:0] alu, input logic [63:0] res,
                       input logic pcmux, input logic [3:0] flags);
      exp_t e;
      e.ir = ir; e.alu = alu; e.res = res; e.pcmux = pcmux; e.flags = flags;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      MEM_V = 1'b0; MEM_FLUSH = 1'b0; MEM_IR = '0; MEM_BR_TAKEN = 1'b0;
   endtask

   task automatic issue(input logic [31:0] ir, input logic [63:0] alu, input logic [63:0] sd, input logic br);
      MEM_V = 1'b1; MEM_IR = ir; MEM_ALU_RESULT = alu; MEM_STORE_DATA = sd;
      MEM_NPC = alu + 64'd4; MEM_BR_TAKEN = br;
   endtask

   // Issue one access, answer it after 'delay' REQ cycles, count stall cycles and
   // capture the bus outputs seen in the first REQ cycle.
   task automatic mem_op(input logic [31:0] ir, input logic [63:0] addr, input logic [63:0] sd,
                         input int delay, input logic [63:0] rdata, input logic err, output int stalls);
      stalls = 0;
      issue(ir, addr, sd, 1'b0);
      @(negedge CLK);
      if (MEM_STALL) stalls++;
      tick();
      for (int c = 0; c <= delay; c++) begin
         if (c == delay) begin
            DMEM_READY = 1'b1; DMEM_RDATA = rdata; DMEM_ERR = err;
         end
         @(negedge CLK);
         if (c == 0) begin
            cap_req = DMEM_REQ; cap_we = DMEM_WE; cap_addr = DMEM_ADDR;
            cap_wdata = DMEM_WDATA; cap_wstrb = DMEM_WSTRB;
         end
         if (MEM_STALL) stalls++;
         tick();
      end
      DMEM_READY = 1'b0; DMEM_ERR = 1'b0;
      idle();
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (RESET === 1'b1 && WB_V === 1'b1) begin
         if (sb.size() == 0) begin
            check("wb_unexpected_valid", 64'(WB_V), 64'd0);
         end else begin
            e = sb.pop_front();
            check("wb_ir", 64'(WB_IR), 64'(e.ir));
            check("wb_alu_result", WB_ALU_RESULT, e.alu);
            check("wb_mem_result", WB_MEM_RESULT, e.res);
            check("wb_pc_mux", 64'(MEM_PC_MUX), 64'(e.pcmux));
            check("wb_exc_flags", 64'({MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF}), 64'(e.flags));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int stalls;
      logic [31:0] ld_a, ld_b;

      RESET = 1'b0; idle();
      MEM_NPC = '0; MEM_ALU_RESULT = '0; MEM_STORE_DATA = '0;
      MEM_CSRFD = 64'h77; MEM_RFD = 64'h66; MEM_DRID = 5'd5; MEM_ECALL = 1'b0;
      DMEM_RDATA = '0; DMEM_READY = 1'b0; DMEM_ERR = 1'b0;

      // Reset holds every registered output at zero even with a valid instruction present.
      issue(mk(3'd0, 7'b0110011, 5'd1), 64'h1234, 64'h0, 1'b1);
      repeat (3) tick();
      @(negedge CLK);
      check("reset_wb_v", 64'(WB_V), 64'd0);
      check("reset_dmem_req", 64'(DMEM_REQ), 64'd0);
      check("reset_wb_fields", WB_ALU_RESULT | 64'(WB_IR) | 64'(MEM_PC_MUX), 64'd0);
      check("reset_flags", 64'({MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF}), 64'd0);
      tick();
      RESET = 1'b1;
      idle();
      tick();

      // Non-memory ops flow through with latency 1 and no stall.
      issue(mk(3'd0, 7'b0110011, 5'd1), 64'h55, 64'h0, 1'b0);
      push(mk(3'd0, 7'b0110011, 5'd1), 64'h55, 64'd0, 1'b0, 4'b0000);
      @(negedge CLK); check("alu_no_stall", 64'(MEM_STALL), 64'd0);
      tick();
      issue(mk(3'd0, 7'b1100011, 5'd0), 64'h2000, 64'h0, 1'b1);
      push(mk(3'd0, 7'b1100011, 5'd0), 64'h2000, 64'd0, 1'b1, 4'b0000);
      tick();
      idle();

      // LD at 0x1000, READY in the first REQ cycle.
      push(mk(3'd3, OPC_LOAD, 5'd2), 64'h1000, 64'h1122334455667788, 1'b0, 4'b0000);
      mem_op(mk(3'd3, OPC_LOAD, 5'd2), 64'h1000, 64'h0, 0, 64'h1122334455667788, 1'b0, stalls);
      check("ld_stall_cycles", 64'(stalls), 64'd1);
      check("ld_bus", {cap_req, cap_we, cap_addr[61:0]}, {1'b1, 1'b0, 62'h1000});
      @(negedge CLK); check("ld_latency_wb_v", 64'(WB_V), 64'd1);

      // Byte / half / word loads with sign and zero extension.
      push(mk(3'd0, OPC_LOAD, 5'd3), 64'h1003, 64'hFFFFFFFFFFFFFF80, 1'b0, 4'b0000);
      mem_op(mk(3'd0, OPC_LOAD, 5'd3), 64'h1003, 64'h0, 0, 64'h0102030480060708, 1'b0, stalls);
      push(mk(3'd4, OPC_LOAD, 5'd3), 64'h1003, 64'h0000000000000080, 1'b0, 4'b0000);
      mem_op(mk(3'd4, OPC_LOAD, 5'd3), 64'h1003, 64'h0, 1, 64'h0102030480060708, 1'b0, stalls);
      push(mk(3'd1, OPC_LOAD, 5'd4), 64'h1006, 64'hFFFFFFFFFFFFF00D, 1'b0, 4'b0000);
      mem_op(mk(3'd1, OPC_LOAD, 5'd4), 64'h1006, 64'h0, 0, 64'hF00D000000000000, 1'b0, stalls);
      push(mk(3'd2, OPC_LOAD, 5'd4), 64'h1004, 64'hFFFFFFFF89ABCDEF, 1'b0, 4'b0000);
      mem_op(mk(3'd2, OPC_LOAD, 5'd4), 64'h1004, 64'h0, 0, 64'h89ABCDEF00000000, 1'b0, stalls);
      push(mk(3'd6, OPC_LOAD, 5'd4), 64'h1004, 64'h0000000089ABCDEF, 1'b0, 4'b0000);
      mem_op(mk(3'd6, OPC_LOAD, 5'd4), 64'h1004, 64'h0, 0, 64'h89ABCDEF00000000, 1'b0, stalls);

      // SH at 0x1006: lane 3 of the doubleword.
      push(mk(3'd1, OPC_STORE, 5'd0), 64'h1006, 64'd0, 1'b0, 4'b0000);
      mem_op(mk(3'd1, OPC_STORE, 5'd0), 64'h1006, 64'h123456789ABCABCD, 1, 64'hFFFF, 1'b0, stalls);
      check("sh_wstrb", 64'(cap_wstrb), 64'hC0);
      check("sh_wdata_hi", 64'(cap_wdata[63:48]), 64'hABCD);
      check("sh_we_addr", {cap_we, cap_addr[62:0]}, {1'b1, 63'h1000});

      // Misaligned LW and SD: no request, no stall, exception next cycle.
      issue(mk(3'd2, OPC_LOAD, 5'd6), 64'h1002, 64'h0, 1'b0);
      push(mk(3'd2, OPC_LOAD, 5'd6), 64'h1002, 64'd0, 1'b0, 4'b1000);
      @(negedge CLK); check("lam_no_stall", 64'(MEM_STALL), 64'd0);
      tick();
      issue(mk(3'd3, OPC_STORE, 5'd0), 64'h1004, 64'h0, 1'b0);
      push(mk(3'd3, OPC_STORE, 5'd0), 64'h1004, 64'd0, 1'b0, 4'b0010);
      @(negedge CLK); check("lam_no_req", 64'(DMEM_REQ), 64'd0);
      tick();
      idle();

      // Flushed misaligned load: no writeback, no flag.
      issue(mk(3'd2, OPC_LOAD, 5'd6), 64'h1002, 64'h0, 1'b0);
      MEM_FLUSH = 1'b1;
      tick();
      idle();
      @(negedge CLK); check("flush_mis_no_wb", 64'({WB_V, MEM_LAM}), 64'd0);

      // SW with READY after 5 wait cycles, answered with ERR.
      push(mk(3'd2, OPC_STORE, 5'd0), 64'h1008, 64'd0, 1'b0, 4'b0001);
      mem_op(mk(3'd2, OPC_STORE, 5'd0), 64'h1008, 64'hDEADBEEF, 5, 64'h0, 1'b1, stalls);
      check("sw_err_stall_cycles", 64'(stalls), 64'd6);
      check("sw_wstrb", 64'(cap_wstrb), 64'h0F);

      // Flush in REQ, READY three cycles later, back-to-back LD waits for IDLE.
      ld_a = mk(3'd3, OPC_LOAD, 5'd7);
      ld_b = mk(3'd3, OPC_LOAD, 5'd8);
      issue(ld_a, 64'h1010, 64'h0, 1'b0);
      tick();
      MEM_FLUSH = 1'b1;
      @(negedge CLK); check("flush_stall_drop", 64'(MEM_STALL), 64'd0);
      tick();
      MEM_FLUSH = 1'b0;
      issue(ld_b, 64'h1018, 64'h0, 1'b0);
      push(ld_b, 64'h1018, 64'hCAFEF00D12345678, 1'b0, 4'b0000);
      for (int c = 1; c <= 3; c++) begin
         if (c == 3) begin DMEM_READY = 1'b1; DMEM_RDATA = 64'h5555; end
         @(negedge CLK);
         check("abort_req_held", 64'({DMEM_REQ, MEM_STALL}), 64'b11);
         tick();
      end
      DMEM_READY = 1'b0;
      @(negedge CLK);
      check("abort_to_idle_issue", 64'({DMEM_REQ, MEM_STALL}), 64'b01);
      tick();
      DMEM_READY = 1'b1; DMEM_RDATA = 64'hCAFEF00D12345678;
      @(negedge CLK); check("b2b_addr", DMEM_ADDR, 64'h1018);
      tick();
      DMEM_READY = 1'b0;
      idle();

      // Timeout: no READY at all.
      push(mk(3'd2, OPC_LOAD, 5'd9), 64'h1020, 64'd0, 1'b0, 4'b0100);
      issue(mk(3'd2, OPC_LOAD, 5'd9), 64'h1020, 64'h0, 1'b0);
      tick();
      n = 0;
      while (n < 200) begin
         @(negedge CLK);
         if (!MEM_STALL) break;
         n++;
         tick();
      end
      check("timeout_cycles", 64'(n), 64'(TMO));
      tick();
      idle();
      DMEM_READY = 1'b1;
      tick();
      DMEM_READY = 1'b0;
      tick();

      // Synchronous reset in the middle of a request.
      issue(mk(3'd3, OPC_LOAD, 5'd10), 64'h1030, 64'h0, 1'b0);
      tick();
      RESET = 1'b0;
      @(negedge CLK); check("rst_mid_req_before", 64'(DMEM_REQ), 64'd1);
      tick();
      @(negedge CLK); check("rst_mid_req_after", 64'(DMEM_REQ), 64'd0);
      idle();
      RESET = 1'b1;
      repeat (3) tick();

      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
